uart_tx_fifo: RTL and testbench



---
 rtl/uart_tx_fifo.sv | 199 +++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter with write FIFO, runtime baud/parity/stop selection.
// Single clock; 16x oversample tick generated from a divisor table.
module uart_tx_fifo #(
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          tx_en,
  input  logic                          tx_wr,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic [2:0]                    baud_sel,
  input  logic [1:0]                    parity_mode,
  input  logic                          stop2,
  output logic                          txd,
  output logic                          tx_busy,
  output logic                          tx_done,
  output logic                          fifo_full,
  output logic                          fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int BW = $clog2(DATA_BITS);
  localparam int DW = $clog2(CLK_HZ / 4800 + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  function automatic logic [DW-1:0] divm1(input logic [2:0] s);
    int unsigned r;
    case (s)
      3'b000:  r = 300;
      3'b001:  r = 1200;
      3'b010:  r = 4800;
      3'b011:  r = 9600;
      3'b100:  r = 19200;
      3'b101:  r = 38400;
      3'b110:  r = 57600;
      default: r = 115200;
    endcase
    return DW'(CLK_HZ / (16 * r) - 1);
  endfunction

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LW-1:0]        level_q, level_d;
  logic                 ovf_q, ovf_d;
  state_e               state_q, state_d;
  logic [DW-1:0]        div_cnt_q, div_cnt_d;
  logic [3:0]           tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 par_q, par_d;
  logic [2:0]           sel_q, sel_d;
  logic [1:0]           pmode_q, pmode_d;
  logic                 stop2_q, stop2_d;
  logic                 txd_q, txd_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic tick, bit_end, last_stop, par_en;
  logic launch, push, pop;

  assign fifo_full  = (level_q == LW'(FIFO_DEPTH));
  assign fifo_empty = (level_q == '0);
  assign fifo_level = level_q;
  assign overflow   = ovf_q;
  assign txd        = txd_q;
  assign tx_busy    = busy_q;
  assign tx_done    = done_q;

  always_comb begin
    tick      = (state_q != IDLE) && (div_cnt_q == divm1(sel_q));
    bit_end   = tick && (tick_cnt_q == 4'd15);
    last_stop = !stop2_q || bit_cnt_q[0];
    par_en    = (pmode_q == 2'b01) || (pmode_q == 2'b10);
    launch    = tx_en && !fifo_empty &&
                ((state_q == IDLE) ||
                 ((state_q == STOP) && bit_end && last_stop));
    push      = tx_wr && tx_en && !fifo_full;
    pop       = launch;

    wptr_d     = push ? wptr_q + AW'(1) : wptr_q;
    rptr_d     = pop ? rptr_q + AW'(1) : rptr_q;
    level_d    = level_q + LW'(push) - LW'(pop);
    ovf_d      = ovf_q | (tx_wr && tx_en && fifo_full);
    state_d    = state_q;
    div_cnt_d  = (state_q == IDLE || tick) ? '0 : div_cnt_q + DW'(1);
    tick_cnt_d = tick ? tick_cnt_q + 4'd1 : tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    data_d     = data_q;
    par_d      = par_q;
    sel_d      = sel_q;
    pmode_d    = pmode_q;
    stop2_d    = stop2_q;
    txd_d      = txd_q;
    busy_d     = busy_q;

    unique case (state_q)
      IDLE: ;
      START: if (bit_end) begin
        state_d   = DATA;
        bit_cnt_d = '0;
        txd_d     = data_q[0];
        data_d    = data_q >> 1;
      end
      DATA: if (bit_end) begin
        if (bit_cnt_q == BW'(DATA_BITS - 1)) begin
          bit_cnt_d = '0;
          state_d   = par_en ? PARITY : STOP;
          txd_d     = par_en ? par_q : 1'b1;
        end else begin
          bit_cnt_d = bit_cnt_q + BW'(1);
          txd_d     = data_q[0];
          data_d    = data_q >> 1;
        end
      end
      PARITY: if (bit_end) begin
        state_d = STOP;
        txd_d   = 1'b1;
      end
      STOP: if (bit_end) begin
        if (!last_stop) begin
          bit_cnt_d = bit_cnt_q + BW'(1);
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
          txd_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // launch overrides frame end so back-to-back frames leave no idle cycle
    if (launch) begin
      state_d    = START;
      data_d     = mem_q[rptr_q];
      par_d      = (^mem_q[rptr_q]) ^ (parity_mode == 2'b10);
      sel_d      = baud_sel;
      pmode_d    = parity_mode;
      stop2_d    = stop2;
      div_cnt_d  = '0;
      tick_cnt_d = '0;
      bit_cnt_d  = '0;
      txd_d      = 1'b0;
      busy_d     = 1'b1;
    end

    // flag the clock carrying the final tick of the last stop bit
    done_d = (state_d == STOP) && (!stop2_d || bit_cnt_d[0]) &&
             (tick_cnt_d == 4'd15) && (div_cnt_d == divm1(sel_d));
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= tx_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      ovf_q      <= 1'b0;
      state_q    <= IDLE;
      div_cnt_q  <= '0;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      data_q     <= '0;
      par_q      <= 1'b0;
      sel_q      <= '0;
      pmode_q    <= '0;
      stop2_q    <= 1'b0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      level_q    <= level_d;
      ovf_q      <= ovf_d;
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      data_q     <= data_d;
      par_q      <= par_d;
      sel_q      <= sel_d;
      pmode_q    <= pmode_d;
      stop2_q    <= stop2_d;
      txd_q      <= txd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: 8-bit instance A, 7-bit instance B.
// 50 MHz, 115200 baud: 27 clk per tick, 432 clk per bit.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tx_en = 1'b0;
  logic       stop2 = 1'b0;
  logic [2:0] baud_sel = 3'b111;
  logic [1:0] parity_mode = 2'b01;

  logic       tx_wr_a = 1'b0;
  logic [7:0] tx_data_a = '0;
  logic       txd_a, busy_a, done_a, full_a, empty_a, ovf_a;
  logic [3:0] level_a;

  logic       tx_wr_b = 1'b0;
  logic [6:0] tx_data_b = '0;
  logic       txd_b, busy_b, done_b, full_b, empty_b, ovf_b;
  logic [3:0] level_b;

  int     ntests = 0;
  int     nfail = 0;
  longint cyc = 0;
  int     done_cnt_a = 0;
  int     done_cnt_b = 0;
  longint done_cyc_a = 0;

  uart_tx_fifo #(.CLK_HZ(50000000), .DATA_BITS(8), .FIFO_DEPTH(8)) dut_a (
    .clk(clk), .reset(reset), .tx_en(tx_en), .tx_wr(tx_wr_a),
    .tx_data(tx_data_a), .baud_sel(baud_sel), .parity_mode(parity_mode),
    .stop2(stop2), .txd(txd_a), .tx_busy(busy_a), .tx_done(done_a),
    .fifo_full(full_a), .fifo_empty(empty_a), .fifo_level(level_a),
    .overflow(ovf_a)
  );

  uart_tx_fifo #(.CLK_HZ(50000000), .DATA_BITS(7), .FIFO_DEPTH(8)) dut_b (
    .clk(clk), .reset(reset), .tx_en(tx_en), .tx_wr(tx_wr_b),
    .tx_data(tx_data_b), .baud_sel(baud_sel), .parity_mode(parity_mode),
    .stop2(stop2), .txd(txd_b), .tx_busy(busy_b), .tx_done(done_b),
    .fifo_full(full_b), .fifo_empty(empty_b), .fifo_level(level_b),
    .overflow(ovf_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (done_a) begin
      done_cnt_a <= done_cnt_a + 1;
      done_cyc_a <= cyc;
    end
    if (done_b) done_cnt_b <= done_cnt_b + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic txd_of(input bit s);
    return s ? txd_b : txd_a;
  endfunction

  // Sample each bit at its centre; off>=0 means already off clocks into START.
  task automatic check_frame(input bit sel, input logic [8:0] d,
                             input int nb, input logic [1:0] pm,
                             input bit s2, input int off,
                             input string tag, output longint t0);
    logic [15:0] e, o;
    int n, k;
    logic p;
    e = '0; o = '0; p = 1'b0;
    e[0] = 1'b0; n = 1;
    for (int i = 0; i < nb; i++) begin
      e[n] = d[i]; p = p ^ d[i]; n++;
    end
    if (pm == 2'b01 || pm == 2'b10) begin
      e[n] = p ^ (pm == 2'b10); n++;
    end
    e[n] = 1'b1; n++;
    if (s2) begin
      e[n] = 1'b1; n++;
    end
    if (off < 0) begin
      k = 0;
      while (txd_of(sel) !== 1'b0 && k < 20000) begin
        @(negedge clk); k++;
      end
      chk({tag, "_start"}, 32'(txd_of(sel)), 32'(0));
      t0 = cyc;
      repeat (216) @(negedge clk);
    end else begin
      t0 = cyc - longint'(off);
      repeat (216 - off) @(negedge clk);
    end
    for (int i = 0; i < n; i++) begin
      o[i] = txd_of(sel);
      if (i < n - 1) repeat (432) @(negedge clk);
    end
    chk(tag, 32'(o), 32'(e));
  endtask

  task automatic wait_idle(input bit sel);
    int k;
    k = 0;
    while ((sel ? busy_b : busy_a) && k < 20000) begin
      @(negedge clk); k++;
    end
  endtask

  initial begin
    longint t0, t1;
    int dc, zeros;

    repeat (3) @(negedge clk);
    chk("rst_txd", 32'(txd_a), 32'(1));
    chk("rst_busy", 32'(busy_a), 32'(0));
    chk("rst_done", 32'(done_a), 32'(0));
    chk("rst_empty", 32'(empty_a), 32'(1));
    chk("rst_full", 32'(full_a), 32'(0));
    chk("rst_level", 32'(level_a), 32'(0));
    chk("rst_ovf", 32'(ovf_a), 32'(0));
    chk("rst_txd_b", 32'(txd_b), 32'(1));
    reset = 1'b1;
    tx_en = 1'b1;
    @(negedge clk);

    // 8E1, 0xA5
    tx_wr_a = 1'b1; tx_data_a = 8'hA5;
    @(negedge clk);
    tx_wr_a = 1'b0;
    chk("t1_level", 32'(level_a), 32'(1));
    dc = done_cnt_a;
    check_frame(1'b0, 9'h0A5, 8, 2'b01, 1'b0, -1, "t1_frame", t0);
    wait_idle(1'b0);
    chk("t1_len", 32'(cyc - t0), 32'(4752));
    chk("t1_done_cnt", 32'(done_cnt_a - dc), 32'(1));
    chk("t1_done_at", 32'(done_cyc_a - t0), 32'(4751));
    chk("t1_txd_idle", 32'(txd_a), 32'(1));

    // 8O2, 0x00
    parity_mode = 2'b10; stop2 = 1'b1;
    tx_wr_a = 1'b1; tx_data_a = 8'h00;
    @(negedge clk);
    tx_wr_a = 1'b0;
    check_frame(1'b0, 9'h000, 8, 2'b10, 1'b1, -1, "t2_frame", t0);
    wait_idle(1'b0);
    chk("t2_len", 32'(cyc - t0), 32'(5184));
    chk("t2_done_at", 32'(done_cyc_a - t0), 32'(5183));

    // 7N1 back-to-back on instance B
    parity_mode = 2'b00; stop2 = 1'b0;
    tx_wr_b = 1'b1; tx_data_b = 7'h7F;
    @(negedge clk);
    chk("t3_level1", 32'(level_b), 32'(1));
    tx_data_b = 7'h01;
    @(negedge clk);
    tx_wr_b = 1'b0;
    chk("t3_level_pushpop", 32'(level_b), 32'(1));
    chk("t3_busy", 32'(busy_b), 32'(1));
    check_frame(1'b1, 9'h07F, 7, 2'b00, 1'b0, 0, "t3_f1", t0);
    check_frame(1'b1, 9'h001, 7, 2'b00, 1'b0, -1, "t3_f2", t1);
    chk("t3_gap", 32'(t1 - t0), 32'(3888));
    chk("t3_level0", 32'(level_b), 32'(0));
    wait_idle(1'b1);
    chk("t3_done_cnt", 32'(done_cnt_b), 32'(2));

    // overflow: 10 consecutive pushes, 0x10..0x19
    tx_wr_a = 1'b1; tx_data_a = 8'h10;
    for (int i = 1; i < 10; i++) begin
      @(negedge clk);
      tx_data_a = 8'h10 + 8'(i);
    end
    @(negedge clk);
    tx_wr_a = 1'b0;
    chk("t4_level", 32'(level_a), 32'(8));
    chk("t4_full", 32'(full_a), 32'(1));
    chk("t4_ovf", 32'(ovf_a), 32'(1));
    check_frame(1'b0, 9'h010, 8, 2'b00, 1'b0, 8, "t4_f0", t0);
    for (int i = 1; i < 9; i++) begin
      check_frame(1'b0, 9'(8'h10 + 8'(i)), 8, 2'b00, 1'b0, -1,
                  $sformatf("t4_f%0d", i), t0);
    end
    wait_idle(1'b0);
    chk("t4_level0", 32'(level_a), 32'(0));
    chk("t4_empty", 32'(empty_a), 32'(1));
    chk("t4_ovf_sticky", 32'(ovf_a), 32'(1));

    // tx_en dropped during DATA with two entries queued
    tx_wr_a = 1'b1; tx_data_a = 8'h5A;
    @(negedge clk);
    tx_data_a = 8'hC3;
    @(negedge clk);
    tx_data_a = 8'h0F;
    @(negedge clk);
    tx_wr_a = 1'b0;
    chk("t5_level2", 32'(level_a), 32'(2));
    fork
      check_frame(1'b0, 9'h05A, 8, 2'b00, 1'b0, 1, "t5_frame", t0);
      begin
        repeat (1100) @(negedge clk);
        tx_en = 1'b0;
      end
    join
    wait_idle(1'b0);
    zeros = 0;
    repeat (1000) begin
      @(negedge clk);
      if (txd_a !== 1'b1 || busy_a !== 1'b0) zeros++;
    end
    chk("t5_quiet", 32'(zeros), 32'(0));
    chk("t5_level_kept", 32'(level_a), 32'(2));
    tx_en = 1'b1;
    @(negedge clk);
    chk("t5_restart_txd", 32'(txd_a), 32'(0));
    chk("t5_restart_busy", 32'(busy_a), 32'(1));
    chk("t5_restart_level", 32'(level_a), 32'(1));

    // reset mid-DATA aborts frame and flushes FIFO
    repeat (216 + 2 * 432) @(negedge clk);
    chk("t6_busy_before", 32'(busy_a), 32'(1));
    reset = 1'b0;
    @(negedge clk);
    chk("t6_txd", 32'(txd_a), 32'(1));
    chk("t6_busy", 32'(busy_a), 32'(0));
    chk("t6_level", 32'(level_a), 32'(0));
    chk("t6_empty", 32'(empty_a), 32'(1));
    chk("t6_ovf", 32'(ovf_a), 32'(0));
    reset = 1'b1;
    @(negedge clk);
    tx_wr_a = 1'b1; tx_data_a = 8'h3C;
    @(negedge clk);
    tx_wr_a = 1'b0;
    check_frame(1'b0, 9'h03C, 8, 2'b00, 1'b0, -1, "t6_frame", t0);
    wait_idle(1'b0);
    chk("t6_len", 32'(cyc - t0), 32'(4320));
    chk("t6_level_end", 32'(level_a), 32'(0));

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
